alu_operand_stage: RTL and testbench

Pipeline stage between the decode/register-file read and the ALU of the 8-bit CPU. Each accepted instruction supplies two register operands, an immediate, and select bits. The stage chooses register or immediate for operand 2, optionally applies two's-complement negation for SUB, and holds the result in a 2-entry skid buffer. It presents the result to the ALU under a valid/ready handshake, so ALU back-pressure never drops an instruction.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/operand_negate.sv | 17 +
 rtl/alu_operand_stage.sv | 112 +++++++++++
 tb/tb_alu_operand_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared widths, ALU opcodes and pipeline types for the 8-bit CPU datapath.
package cpu_pkg;

  localparam int DATA_W  = 8;
  localparam int ALUOP_W = 3;

  localparam logic [ALUOP_W-1:0] ALU_FWD = 3'b000;
  localparam logic [ALUOP_W-1:0] ALU_ADD = 3'b001;
  localparam logic [ALUOP_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 3'b011;

  typedef struct packed {
    logic [DATA_W-1:0]  op1;
    logic [DATA_W-1:0]  op2;
    logic [ALUOP_W-1:0] aluop;
    logic               neg_ovf;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/operand_negate.sv
// Optional two's-complement negation of operand 2; flags the one input
// (most negative value) whose negation is not representable.
module operand_negate #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] src,
  input  logic              neg,
  output logic [DATA_W-1:0] op2,
  output logic              ovf
);

  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  assign op2 = neg ? (~src + DATA_W'(1'b1)) : src;
  assign ovf = neg && (src == MOST_NEG);

endmodule

// File: rtl/alu_operand_stage.sv
// Operand-2 select/negate followed by a 2-entry skid buffer feeding the ALU
// under a valid/ready handshake.
module alu_operand_stage #(
  parameter int DATA_W  = 8,
  parameter int ALUOP_W = 3
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               FLUSH,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [DATA_W-1:0]  REGOUT1,
  input  logic [DATA_W-1:0]  REGOUT2,
  input  logic [DATA_W-1:0]  IMMEDIATE,
  input  logic               IMM_SEL,
  input  logic               NEG_SEL,
  input  logic [ALUOP_W-1:0] ALUOP_IN,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [DATA_W-1:0]  OPERAND1,
  output logic [DATA_W-1:0]  OPERAND2,
  output logic [ALUOP_W-1:0] ALUOP,
  output logic               NEG_OVF
);

  import cpu_pkg::*;

  logic [DATA_W-1:0] op2_src;
  logic [DATA_W-1:0] op2_neg;
  logic              op2_ovf;
  entry_t            new_entry;

  occ_e   state_q, state_d;
  entry_t head_q, head_d;
  entry_t tail_q, tail_d;
  logic   in_ready_q, out_valid_q;
  logic   push, pop;

  assign op2_src = IMM_SEL ? IMMEDIATE : REGOUT2;

  operand_negate #(.DATA_W(DATA_W)) u_negate (
    .src (op2_src),
    .neg (NEG_SEL),
    .op2 (op2_neg),
    .ovf (op2_ovf)
  );

  assign new_entry = '{op1: REGOUT1, op2: op2_neg, aluop: ALUOP_IN, neg_ovf: op2_ovf};

  assign push = IN_VALID && in_ready_q;
  assign pop  = out_valid_q && OUT_READY;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (FLUSH) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (push) begin
          head_d  = new_entry;
          state_d = ONE;
        end
        ONE: begin
          if (push && pop) begin
            head_d = new_entry;
          end else if (push) begin
            tail_d  = new_entry;
            state_d = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: if (pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
    end
  end

  // NOTE: entry data is not reset; outputs are masked by out_valid_q, so stale
  // contents are never visible.
  always_ff @(posedge CLK) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

  assign IN_READY  = in_ready_q;
  assign OUT_VALID = out_valid_q;
  assign OPERAND1  = out_valid_q ? head_q.op1     : '0;
  assign OPERAND2  = out_valid_q ? head_q.op2     : '0;
  assign ALUOP     = out_valid_q ? head_q.aluop   : '0;
  assign NEG_OVF   = out_valid_q ? head_q.neg_ovf : 1'b0;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: the driver queues expected entries on
// acceptance, a negedge monitor pops and compares on every handshake.
module tb_alu_operand_stage;

  import cpu_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       FLUSH;
  logic       IN_VALID;
  logic       IN_READY;
  logic [7:0] REGOUT1, REGOUT2, IMMEDIATE;
  logic       IMM_SEL, NEG_SEL;
  logic [2:0] ALUOP_IN;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic [7:0] OPERAND1, OPERAND2;
  logic [2:0] ALUOP;
  logic       NEG_OVF;

  alu_operand_stage #(.DATA_W(8), .ALUOP_W(3)) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .FLUSH     (FLUSH),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .REGOUT1   (REGOUT1),
    .REGOUT2   (REGOUT2),
    .IMMEDIATE (IMMEDIATE),
    .IMM_SEL   (IMM_SEL),
    .NEG_SEL   (NEG_SEL),
    .ALUOP_IN  (ALUOP_IN),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OPERAND1  (OPERAND1),
    .OPERAND2  (OPERAND2),
    .ALUOP     (ALUOP),
    .NEG_OVF   (NEG_OVF)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] op1;
    logic [7:0] op2;
    logic [2:0] aluop;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   out_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: handshake is decided at the next rising edge, inputs are stable here.
  always @(negedge CLK) begin
    if (RESET_N && OUT_VALID && OUT_READY) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_output: got op1 0x%0h expected no output at %0t", OPERAND1, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_op1",   OPERAND1, e.op1);
        check("out_op2",   OPERAND2, e.op2);
        check("out_aluop", ALUOP,    e.aluop);
        check("out_ovf",   NEG_OVF,  e.ovf);
      end
      out_count++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  // Called 2ns after a rising edge; returns 2ns after the accepting edge.
  task automatic push_vec(input logic [7:0] op1, input logic [7:0] r2, input logic [7:0] imm,
                          input logic isel, input logic nsel, input logic [2:0] op,
                          input logic [7:0] e2, input logic eovf);
    logic rdy;
    int   waited = 0;
    bit   done = 0;
    REGOUT1 = op1; REGOUT2 = r2; IMMEDIATE = imm;
    IMM_SEL = isel; NEG_SEL = nsel; ALUOP_IN = op; IN_VALID = 1'b1;
    while (!done) begin
      rdy = IN_READY;
      @(posedge CLK);
      if (rdy) begin
        exp_q.push_back('{op1: op1, op2: e2, aluop: op, ovf: eovf});
        done = 1;
      end else if (++waited > 50) begin
        n_total++;
        $display("FAIL push_timeout: got IN_READY 0 for %0d cycles expected acceptance", waited);
        done = 1;
      end
      #2;
    end
    IN_VALID = 1'b0;
    REGOUT1 = 8'hEE; REGOUT2 = 8'hEE; IMMEDIATE = 8'hEE;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"},  IN_READY,  1);
    check({tag, "_out_valid"}, OUT_VALID, 0);
    check({tag, "_operand1"},  OPERAND1,  0);
    check({tag, "_operand2"},  OPERAND2,  0);
    check({tag, "_aluop"},     ALUOP,     0);
    check({tag, "_neg_ovf"},   NEG_OVF,   0);
  endtask

  logic [7:0] s_src [10] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
  logic [7:0] s_exp [10] = '{8'h01, 8'hFE, 8'h03, 8'hFC, 8'h05, 8'hFA, 8'h07, 8'hF8, 8'h09, 8'hF6};

  initial begin
    int base;
    int guard;
    RESET_N = 1'b0; FLUSH = 1'b0; OUT_READY = 1'b1;
    IN_VALID = 1'b1; REGOUT1 = 8'h99; REGOUT2 = 8'h99; IMMEDIATE = 8'h99;
    IMM_SEL = 1'b0; NEG_SEL = 1'b0; ALUOP_IN = ALU_OR;
    step(2);
    check_idle("reset");
    RESET_N = 1'b1; IN_VALID = 1'b0;

    // Register negate, then negation corners and plain pass-through.
    push_vec(8'h01, 8'h05, 8'h00, 1'b0, 1'b1, ALU_ADD, 8'hFB, 1'b0);
    check("lat_out_valid", OUT_VALID, 1);
    check("lat_operand2",  OPERAND2,  8'hFB);
    check("lat_neg_ovf",   NEG_OVF,   0);
    push_vec(8'h02, 8'h00, 8'h80, 1'b1, 1'b1, ALU_ADD, 8'h80, 1'b1);
    push_vec(8'h03, 8'h00, 8'h00, 1'b1, 1'b1, ALU_ADD, 8'h00, 1'b0);
    push_vec(8'h04, 8'h3C, 8'h00, 1'b0, 1'b0, ALU_AND, 8'h3C, 1'b0);
    push_vec(8'h05, 8'h00, 8'h7F, 1'b1, 1'b0, ALU_OR,  8'h7F, 1'b0);
    push_vec(8'h06, 8'h00, 8'h01, 1'b1, 1'b1, ALU_FWD, 8'hFF, 1'b0);
    push_vec(8'h07, 8'hFF, 8'h80, 1'b0, 1'b1, ALU_ADD, 8'h01, 1'b0);
    push_vec(8'h08, 8'h80, 8'h00, 1'b0, 1'b0, ALU_FWD, 8'h80, 1'b0);
    step(2);

    // Back-pressure fills both entries, then drains in order.
    OUT_READY = 1'b0;
    push_vec(8'h11, 8'h10, 8'h00, 1'b0, 1'b0, ALU_ADD, 8'h10, 1'b0);
    push_vec(8'h22, 8'h00, 8'h20, 1'b1, 1'b1, ALU_AND, 8'hE0, 1'b0);
    check("bp_in_ready",  IN_READY,  0);
    check("bp_out_valid", OUT_VALID, 1);
    check("bp_head_op1",  OPERAND1,  8'h11);
    OUT_READY = 1'b1;
    step(2);
    check_idle("drained");

    // Ten back-to-back instructions with the ALU always ready.
    base = out_count;
    for (int i = 0; i < 10; i++) begin
      check("stream_in_ready", IN_READY, 1);
      push_vec(8'h30 + 8'(i), 8'h00, s_src[i], 1'b1, (i % 2 == 1), 3'(i), s_exp[i], 1'b0);
    end
    @(negedge CLK); #1;
    check("stream_out_count", out_count - base, 10);
    step(1);
    check("stream_done_valid", OUT_VALID, 0);

    // Flush while FULL with a push offered in the same cycle.
    OUT_READY = 1'b0;
    push_vec(8'h33, 8'h01, 8'h00, 1'b0, 1'b0, ALU_ADD, 8'h01, 1'b0);
    push_vec(8'h44, 8'h02, 8'h00, 1'b0, 1'b0, ALU_ADD, 8'h02, 1'b0);
    check("full_in_ready", IN_READY, 0);
    FLUSH = 1'b1; IN_VALID = 1'b1; REGOUT1 = 8'hEE; IMM_SEL = 1'b0; NEG_SEL = 1'b0;
    @(posedge CLK);
    exp_q.delete();
    #2;
    FLUSH = 1'b0; IN_VALID = 1'b0;
    check_idle("flush");
    OUT_READY = 1'b1;
    push_vec(8'h55, 8'h00, 8'h05, 1'b1, 1'b1, ALU_OR, 8'hFB, 1'b0);
    step(2);

    // Asynchronous reset while FULL with a push pending.
    OUT_READY = 1'b0;
    push_vec(8'h66, 8'h06, 8'h00, 1'b0, 1'b0, ALU_ADD, 8'h06, 1'b0);
    push_vec(8'h77, 8'h07, 8'h00, 1'b0, 1'b0, ALU_ADD, 8'h07, 1'b0);
    IN_VALID = 1'b1; REGOUT1 = 8'hDD;
    #1;
    RESET_N = 1'b0;
    #1;
    exp_q.delete();
    check_idle("async_reset");
    step(1);
    check("reset_hold_valid", OUT_VALID, 0);
    RESET_N = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1;
    push_vec(8'h88, 8'h00, 8'h03, 1'b1, 1'b0, ALU_AND, 8'h03, 1'b0);

    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      step(1);
      guard++;
    end
    check("queue_drained", exp_q.size(), 0);
    step(1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
